axonerve_wordcount_axi_mem_responder: RTL

- AXI4 slave memory model that answers the kernel's m00_axi master port: the reduced AW/W/B/AR/R signal set, with no id, size, burst or resp fields.
- Backs global memory with an on-chip word array; write and read channels run independent burst FSMs.
- Used as the memory endpoint in kernel-level simulation and as an on-chip scratch memory for standalone wordcount bring-up.

---
 rtl/axonerve_wordcount_mem_pkg.sv | 23 ++
 rtl/axonerve_wordcount_axi_mem_responder_array.sv | 43 ++++
 rtl/axonerve_wordcount_axi_mem_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axonerve_wordcount_mem_pkg.sv
// Shared types, state encodings and address helpers for the wordcount AXI memory responder.
package axonerve_wordcount_mem_pkg;

    localparam int LP_DATA_W_DEF = 512;
    localparam int LP_BYTE_OFF_W = $clog2(LP_DATA_W_DEF / 8);

    typedef logic [1:0] w_state_t;
    localparam w_state_t W_IDLE = 2'd0;
    localparam w_state_t W_DATA = 2'd1;
    localparam w_state_t W_RESP = 2'd2;

    typedef logic [0:0] r_state_t;
    localparam r_state_t R_IDLE = 1'b0;
    localparam r_state_t R_DATA = 1'b1;

    // Word index of a byte address: drop the byte-offset bits, keep idx_w bits.
    function automatic logic [31:0] word_index(input logic [63:0] addr,
                                               input int idx_w,
                                               input int off_w = LP_BYTE_OFF_W);
        return 32'((addr >> off_w) & ((64'd1 << idx_w) - 64'd1));
    endfunction

endpackage

// File: rtl/axonerve_wordcount_axi_mem_responder_array.sv
// Dual-port word array: byte-enable write port, registered read-first read port.
module axonerve_wordcount_mem_array #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Contents are deliberately not reset so data survives ap_rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axonerve_wordcount_axi_mem_responder.sv
// AXI4 slave memory model for the wordcount m00_axi port; independent write and read burst FSMs.
// Optional sticky protocol checker built only when AXIMEM_PROTOCOL_CHECK_EN is defined.
module axonerve_wordcount_axi_mem_responder
    import axonerve_wordcount_mem_pkg::*;
#(
    parameter int C_ADDR_WIDTH  = 64,
    parameter int C_DATA_WIDTH  = 512,
    parameter int C_DEPTH_WORDS = 1024
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                      s_axi_rlast,
    output logic                      proto_err
);

    localparam int BYTE_OFF_W = $clog2(C_DATA_WIDTH / 8);
    localparam int IDX_W      = $clog2(C_DEPTH_WORDS);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both 1;
    // every ready/valid output here is a pure decode of FSM state, so none depends on inputs.
    w_state_t         w_state_q, w_state_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [8:0]       w_cnt_q, w_cnt_d;
    r_state_t         r_state_q, r_state_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d;
    logic [8:0]       r_cnt_q, r_cnt_d;
    logic             rlast_q, rlast_d;
    logic             mem_we, mem_re;
    logic [IDX_W-1:0] mem_raddr, aw_idx, ar_idx;

    assign aw_idx = IDX_W'(word_index(64'(s_axi_awaddr), IDX_W, BYTE_OFF_W));
    assign ar_idx = IDX_W'(word_index(64'(s_axi_araddr), IDX_W, BYTE_OFF_W));

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (s_axi_awvalid) begin
                w_state_d = W_DATA;
                w_idx_d   = aw_idx;
                w_cnt_d   = {1'b0, s_axi_awlen} + 9'd1;
            end
            W_DATA: if (s_axi_wvalid) begin
                mem_we  = 1'b1;
                w_idx_d = w_idx_q + IDX_W'(1);
                w_cnt_d = w_cnt_q - 9'd1;
                // The beat count, not wlast, terminates the burst.
                if (w_cnt_q == 9'd1) w_state_d = W_RESP;
            end
            W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        rlast_d   = rlast_q;
        mem_re    = 1'b0;
        mem_raddr = r_idx_q;
        case (r_state_q)
            R_IDLE: if (s_axi_arvalid) begin
                r_state_d = R_DATA;
                r_idx_d   = ar_idx;
                r_cnt_d   = {1'b0, s_axi_arlen} + 9'd1;
                rlast_d   = (s_axi_arlen == 8'd0);
                mem_re    = 1'b1;
                mem_raddr = ar_idx;
            end
            R_DATA: if (s_axi_rready) begin
                if (r_cnt_q == 9'd1) begin
                    r_state_d = R_IDLE;
                    rlast_d   = 1'b0;
                end else begin
                    // Prefetch the next word on the same edge for back-to-back beats.
                    r_idx_d   = r_idx_q + IDX_W'(1);
                    r_cnt_d   = r_cnt_q - 9'd1;
                    rlast_d   = (r_cnt_q == 9'd2);
                    mem_re    = 1'b1;
                    mem_raddr = r_idx_q + IDX_W'(1);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            rlast_q   <= rlast_d;
        end
    end

    axonerve_wordcount_mem_array #(
        .DATA_W (C_DATA_WIDTH),
        .DEPTH  (C_DEPTH_WORDS)
    ) u_array (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .we    (mem_we),
        .waddr (w_idx_q),
        .wdata (s_axi_wdata),
        .wstrb (s_axi_wstrb),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (s_axi_rdata)
    );

    assign s_axi_awready = (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_arready = (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rlast   = rlast_q;

`ifdef AXIMEM_PROTOCOL_CHECK_EN
    logic proto_err_q, proto_err_d;

    always_comb begin
        proto_err_d = proto_err_q;
        if (w_state_q == W_IDLE && s_axi_awvalid &&
            ((s_axi_awaddr[BYTE_OFF_W-1:0] != '0) ||
             (32'(aw_idx) + 32'(s_axi_awlen) > 32'(C_DEPTH_WORDS - 1))))
            proto_err_d = 1'b1;
        if (r_state_q == R_IDLE && s_axi_arvalid &&
            ((s_axi_araddr[BYTE_OFF_W-1:0] != '0) ||
             (32'(ar_idx) + 32'(s_axi_arlen) > 32'(C_DEPTH_WORDS - 1))))
            proto_err_d = 1'b1;
        if (w_state_q == W_DATA && s_axi_wvalid && (s_axi_wlast != (w_cnt_q == 9'd1)))
            proto_err_d = 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) proto_err_q <= 1'b0;
        else           proto_err_q <= proto_err_d;
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr, s_axi_wlast};

endmodule
